// File: rtl/disk_dma_pkg.sv
// disk_dma_pkg: state encoding, transfer direction codes and default device sizes
// shared by disk_dma_ctrl and its helpers.
package disk_dma_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCheck = 3'd1,
    StRead  = 3'd2,
    StWrite = 3'd3,
    StDone  = 3'd4
  } dma_state_e;

  localparam logic DIR_DISK2MEM = 1'b0;
  localparam logic DIR_MEM2DISK = 1'b1;

  localparam int unsigned DISK_SIZE_DEFAULT = 150;
  localparam int unsigned MEM_SIZE_DEFAULT  = 256;

endpackage

// File: rtl/dma_range_check.sv
// dma_range_check: reports whether the word window [base, base+length) fits inside a
// device of size words; the sum is formed in 33 bits so it cannot wrap.
module dma_range_check (
  input  logic [31:0] base,
  input  logic [31:0] length,
  input  logic [31:0] size,
  output logic        ok
);

  logic [32:0] end_excl;

  assign end_excl = {1'b0, base} + {1'b0, length};
  assign ok       = (end_excl <= {1'b0, size});

endmodule

// File: rtl/disk_dma_ctrl.sv
// disk_dma_ctrl: word-serial DMA between disk and memory, two cycles per word.
// Define DISK_DMA_CHECKSUM_EN to add a running checksum output of the words written.
module disk_dma_ctrl
  import disk_dma_pkg::*;
#(
  parameter int unsigned DISK_SIZE = DISK_SIZE_DEFAULT,
  parameter int unsigned MEM_SIZE  = MEM_SIZE_DEFAULT,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dir,
  input  logic [31:0]       src_base,
  input  logic [31:0]       dst_base,
  input  logic [31:0]       length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       count,
`ifdef DISK_DMA_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic [31:0]       disk_addr,
  output logic              disk_we,
  output logic [DATA_W-1:0] disk_wdata,
  input  logic [DATA_W-1:0] disk_rdata,
  output logic [31:0]       mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  dma_state_e        state_q, state_d;
  logic              dir_q, dir_d;
  logic [31:0]       src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic [31:0]       count_q, count_d;
  logic              err_q, err_d;
  logic [31:0]       disk_addr_q, disk_addr_d, mem_addr_q, mem_addr_d;
  logic              disk_we_q, disk_we_d, mem_we_q, mem_we_d;
  logic [DATA_W-1:0] disk_wdata_q, disk_wdata_d, mem_wdata_q, mem_wdata_d;

  logic [31:0]       src_size, dst_size;
  logic              src_ok, dst_ok;
  logic [DATA_W-1:0] src_rdata;

  assign src_size  = (dir_q == DIR_DISK2MEM) ? 32'(DISK_SIZE) : 32'(MEM_SIZE);
  assign dst_size  = (dir_q == DIR_DISK2MEM) ? 32'(MEM_SIZE) : 32'(DISK_SIZE);
  assign src_rdata = (dir_q == DIR_MEM2DISK) ? mem_rdata : disk_rdata;

  dma_range_check u_src_check (
    .base   (src_q),
    .length (len_q),
    .size   (src_size),
    .ok     (src_ok)
  );

  dma_range_check u_dst_check (
    .base   (dst_q),
    .length (len_q),
    .size   (dst_size),
    .ok     (dst_ok)
  );

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    count_d      = count_q;
    err_d        = err_q;
    disk_addr_d  = disk_addr_q;
    disk_wdata_d = disk_wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    disk_we_d    = 1'b0;
    mem_we_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          dir_d   = dir;
          src_d   = src_base;
          dst_d   = dst_base;
          len_d   = length;
          count_d = '0;
          err_d   = 1'b0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (!src_ok || !dst_ok || (len_q > DISK_SIZE)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (len_q == '0) begin
          state_d = StDone;
        end else begin
          state_d = StRead;
          if (dir_q == DIR_DISK2MEM) disk_addr_d = src_q;
          else                       mem_addr_d  = src_q;
        end
      end
      // Source data lands at the edge leaving READ and becomes the write data.
      StRead: begin
        state_d = StWrite;
        if (dir_q == DIR_DISK2MEM) begin
          mem_addr_d  = dst_q + count_q;
          mem_wdata_d = src_rdata;
          mem_we_d    = 1'b1;
        end else begin
          disk_addr_d  = dst_q + count_q;
          disk_wdata_d = src_rdata;
          disk_we_d    = 1'b1;
        end
      end
      StWrite: begin
        count_d = count_q + 32'd1;
        if (count_d == len_q) begin
          state_d = StDone;
        end else begin
          state_d = StRead;
          if (dir_q == DIR_DISK2MEM) disk_addr_d = src_q + count_d;
          else                       mem_addr_d  = src_q + count_d;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      dir_q        <= DIR_DISK2MEM;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
      disk_addr_q  <= '0;
      disk_we_q    <= 1'b0;
      disk_wdata_q <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      count_q      <= count_d;
      err_q        <= err_d;
      disk_addr_q  <= disk_addr_d;
      disk_we_q    <= disk_we_d;
      disk_wdata_q <= disk_wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

`ifdef DISK_DMA_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      checksum_q <= '0;
    end else if (state_q == StRead) begin
      checksum_q <= checksum_q + src_rdata;
    end
  end

  assign checksum = checksum_q;
`endif

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign err        = err_q;
  assign count      = count_q;
  assign disk_addr  = disk_addr_q;
  assign disk_we    = disk_we_q;
  assign disk_wdata = disk_wdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: doc/disk_dma_ctrl.md
Name: disk_dma_ctrl

Overview:
- Word-serial DMA controller that sequences disco_rigido against the instruction/data memory.
- Used by the boot path and OS loader to copy program images from disk into memory (DISK2MEM) or save memory regions back to disk (MEM2DISK).
- Owns disk/memory address, write-enable and write-data buses while busy; the CPU starts a transfer and polls or waits for done.

Parameters:
- DISK_SIZE, 150, number of 32-bit disk words; valid disk addresses are 0..DISK_SIZE-1.
- MEM_SIZE, 256, number of 32-bit memory words; valid memory addresses are 0..MEM_SIZE-1.
- DATA_W, 32, word width.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- dir  in  1  0 = DISK2MEM, 1 = MEM2DISK; latched on accepted start.
- src_base  in  32  first source word address; latched on start.
- dst_base  in  32  first destination word address; latched on start.
- length  in  32  number of words to copy; latched on start.
- busy  out  1  high from the cycle after an accepted start until DONE is left.
- done  out  1  one-cycle pulse on completion or error.
- err  out  1  sticky range error; cleared by the next accepted start or by reset.
- count  out  32  words written so far in the current transfer.
- disk_addr  out  32  disk word address.
- disk_we  out  1  disk write enable.
- disk_wdata  out  32  data to disk.
- disk_rdata  in  32  disk read data, valid at the posedge following the cycle in which disk_addr was driven (disk updates on negedge).
- mem_addr  out  32  memory word address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  32  data to memory.
- mem_rdata  in  32  memory read data; same timing as disk_rdata.

Behaviour:
- Reset values: busy=0, done=0, err=0, count=0, disk_we=0, mem_we=0, all address/data outputs 0, state=IDLE.
- Reset mid-transfer aborts at that edge. Write enables are low from the next cycle; no done pulse is issued.
- IDLE
  - start=1 latches dir, src_base, dst_base, length, clears err and count, and moves to CHECK.
  - start=0 stays in IDLE.
- CHECK (one cycle)
  - Error if src_base+length or dst_base+length exceeds the relevant size (computed in 33 bits, so no wrap), or if length > DISK_SIZE. Set err=1 and go to DONE with no writes.
  - length=0: go to DONE with err=0 and no writes.
  - Otherwise go to READ.
- READ
  - Drive the source address (src_base+count) on the source bus with we=0. Go to WRITE.
- WRITE
  - Capture source rdata into the destination wdata.
  - Drive the destination address (dst_base+count) with we=1 for exactly this cycle.
  - Increment count at the end of the cycle.
  - If count+1 == length go to DONE, else go to READ.
- Throughput: 2 cycles per word. Total latency from start to done = 2 + 2*length cycles (done asserted in DONE).
- DONE
  - done=1 for one cycle, busy drops the following cycle, then IDLE.
- Bus control: the idle bus for the current direction holds we=0.
- Start handling: start while not IDLE is ignored (no queuing). Start in the same cycle done is high is also ignored.
- Address arithmetic: 32-bit, with no wrap needed thanks to the CHECK guarantee.
- Overlap: src/dst overlap is impossible because the regions are on different devices.

Optional Feature:
- Macro DISK_DMA_CHECKSUM_EN.
- Defined:
  - Extra output port checksum (32) holds a running modulo-2^32 sum of every word written during the transfer.
  - Cleared on accepted start and on reset; stable after done.
- Undefined:
  - Port and adder are absent; all other behaviour is identical.

Decomposition:
- Package disk_dma_pkg holds:
  - state encoding (IDLE, CHECK, READ, WRITE, DONE, 3 bits);
  - DIR_DISK2MEM=0 and DIR_MEM2DISK=1;
  - default DISK_SIZE/MEM_SIZE constants.
- Sub-module dma_range_check is combinational: base, length, size in; ok out. It is instantiated twice, for source and destination.

Test Plan:
- DISK2MEM, src_base=0, dst_base=0, length=47, disk preloaded with the boot image:
  - mem[0..46] equals disk[0..46];
  - done occurs 96 cycles after start; err=0; count=47.
- MEM2DISK, src_base=10, dst_base=100, length=5, mem[10..14]=1..5:
  - disk[100..104]=1..5;
  - disk_we pulses exactly 5 times, each one cycle wide.
- length=0:
  - done arrives 2 cycles after start; no we pulses; err=0.
- DISK2MEM with src_base=140, length=20:
  - err=1 and done at cycle 2; no writes.
  - A following valid start clears err.
- Reset at word 3 of a length=10 transfer:
  - we low the next cycle; busy=0; count=0; no done pulse; memory words 3 and above untouched.
- Start pulsed while busy:
  - ignored; the original transfer completes unchanged.
  - With DISK_DMA_CHECKSUM_EN defined, checksum for MEM2DISK words 1..5 equals 15.
